// File: rtl/output_uart_tx.sv
// output_uart_tx: captures CPU output-register writes (nLo strobe) into a
// small FIFO and serializes each byte as an 8N1 UART frame on tx.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//   FIFO_DEPTH    FIFO entries (power of two, >= 2)
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   n_load     active-low capture strobe (nLo)
//   bus[7:0]   shared CPU bus, sampled while n_load is low
//   tx         registered serial output, idles high
//   busy       frame in flight or FIFO non-empty
//   fifo_full  FIFO count equals FIFO_DEPTH
//   overflow   sticky, set when a capture is dropped
// Build option: define UART_PARITY_EN to append an even-parity bit after
// the data bits (11 bit-times per frame instead of 10).

module output_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       n_load,
  input  logic [7:0] bus,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] BAUD_MAX =
    BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C =
    CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  // ---------------------------------------------------------------
  // State
  // ---------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;

  // ---------------------------------------------------------------
  // Shared combinational status
  // ---------------------------------------------------------------
  logic       push;
  logic       push_ok;
  logic       pop;
  logic       full;
  logic       empty;
  logic       baud_end;
  logic [7:0] head;

  assign push     = !n_load;
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign baud_end = (baud_q == BAUD_MAX);
  assign head     = mem_q[rd_ptr_q];

  // A full FIFO still accepts a byte when the head
  // leaves on the same edge.
  assign push_ok  = push && (!full || pop);

  // ---------------------------------------------------------------
  // FIFO next state
  // ---------------------------------------------------------------
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = bus;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    if (push && !push_ok) begin
      ovf_d = 1'b1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------
  // Transmit FSM next state
  // tx_d always carries the level of the bit that starts on the
  // coming edge, so tx_q changes exactly at bit boundaries.
  // ---------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = data_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          data_d  = head;
          state_d = START;
          baud_d  = '0;
          tx_d    = 1'b0;
        end
      end

      START: begin
        if (baud_end) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = data_q[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = PARITY;
            tx_d    = ^data_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = data_q[bit_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

`ifdef UART_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          state_d = STOP;
          baud_d  = '0;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`endif

      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next frame when
          // more bytes are waiting.
          if (!empty) begin
            pop     = 1'b1;
            data_d  = head;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      tx_q     <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      tx_q     <= tx_d;
    end
  end

  // ---------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------
  assign tx        = tx_q;
  assign busy      = (state_q != IDLE) || !empty;
  assign fifo_full = full;
  assign overflow  = ovf_q;

endmodule
